// File: rtl/pueo_beam_pkg.sv
// pueo_beam_pkg
//   Shared definitions for the beam-mask Wishbone loader: loader and access
//   engine state encodings, mask register offsets, the update-request bit
//   position, the beam count and the error codes reported on err_code_o.
package pueo_beam_pkg;

   localparam int NBEAMS     = 48;
   localparam int UPDATE_BIT = 31;

   // Byte offsets of the two mask registers from the block base address.
   localparam logic [3:0] MASK_REG_0 = 4'h8;
   localparam logic [3:0] MASK_REG_1 = 4'hC;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_BUS      = 2'b01;  // wb_err_i or retries exhausted
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_MISMATCH = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR0,
      ST_GAP,
      ST_WR1,
      ST_RD0,
      ST_RD1,
      ST_DONE
   } loader_state_t;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_BUS,
      ACC_REISSUE
   } access_state_t;

endpackage

// File: rtl/wb_single_access.sv
// wb_single_access
//   Performs one Wishbone read or write, including timeout and retry
//   handling. Bus controls are registered and come up on the edge that
//   samples start.
//
//   Handshake: start is sampled only while the engine is idle and launches
//   one access with the we/adr/dat presented in that cycle. done is a
//   one-cycle strobe, high in the same cycle as the terminating bus response
//   (or timeout), with status and rdata valid alongside it. The bus
//   controls drop on the following edge, so a start issued in the next
//   cycle yields exactly one idle bus cycle between accesses.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, we, adr, dat  access request
//   done, rdata, status  access completion (status uses ERR_* codes)
//   bus_*                Wishbone initiator side
module wb_single_access
   import pueo_beam_pkg::*;
#(
   parameter logic [7:0] TIMEOUT   = 8'd255,
   parameter int         MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [14:0] adr,
   input  logic [31:0] dat,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  status,
   output logic        bus_cyc,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [14:0] bus_adr,
   output logic [31:0] bus_wdat,
   input  logic [31:0] bus_rdat,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic        bus_rty
);

   localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

   access_state_t state;
   logic [7:0]    tcnt;
   logic [7:0]    rcnt;
   logic          l_we;
   logic [31:0]   l_dat;
   logic          reissue;

   assign rdata = bus_rdat;

   // Termination decode; err beats rty beats ack. Timeout only fires when
   // no response is present in the same cycle.
   always_comb begin
      done    = 1'b0;
      status  = ERR_NONE;
      reissue = 1'b0;
      if (state == ACC_BUS) begin
         if (bus_err) begin
            done   = 1'b1;
            status = ERR_BUS;
         end else if (bus_rty) begin
            if (rcnt != RETRY_LIMIT) begin
               reissue = 1'b1;
            end else begin
               done   = 1'b1;
               status = ERR_BUS;
            end
         end else if (bus_ack) begin
            done = 1'b1;
         end else if ((tcnt + 8'd1) == TIMEOUT) begin
            done   = 1'b1;
            status = ERR_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ACC_IDLE;
         tcnt     <= 8'd0;
         rcnt     <= 8'd0;
         l_we     <= 1'b0;
         l_dat    <= 32'd0;
         bus_cyc  <= 1'b0;
         bus_stb  <= 1'b0;
         bus_we   <= 1'b0;
         bus_adr  <= 15'd0;
         bus_wdat <= 32'd0;
      end else begin
         case (state)
            ACC_IDLE: begin
               if (start) begin
                  l_we     <= we;
                  l_dat    <= we ? dat : 32'd0;
                  bus_cyc  <= 1'b1;
                  bus_stb  <= 1'b1;
                  bus_we   <= we;
                  bus_adr  <= adr;
                  bus_wdat <= we ? dat : 32'd0;
                  tcnt     <= 8'd0;
                  rcnt     <= 8'd0;
                  state    <= ACC_BUS;
               end
            end
            ACC_BUS: begin
               if (done || reissue) begin
                  bus_cyc  <= 1'b0;
                  bus_stb  <= 1'b0;
                  bus_we   <= 1'b0;
                  bus_wdat <= 32'd0;
                  if (reissue) begin
                     rcnt  <= rcnt + 8'd1;
                     state <= ACC_REISSUE;
                  end else begin
                     state <= ACC_IDLE;
                  end
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            ACC_REISSUE: begin
               // One idle cycle has elapsed; repeat the same access with a
               // fresh timeout window. The address register was left intact.
               bus_cyc  <= 1'b1;
               bus_stb  <= 1'b1;
               bus_we   <= l_we;
               bus_wdat <= l_dat;
               tcnt     <= 8'd0;
               state    <= ACC_BUS;
            end
            default: state <= ACC_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/beam_mask_wb_loader.sv
// beam_mask_wb_loader
//   Loads a 48-bit beam mask into a remote register block over Wishbone:
//   low 18 bits to BASE_ADDR+8 (no update), then the high 30 bits to
//   BASE_ADDR+'hC with bit 31 set to request the atomic mask update.
//   Optional readback of both registers is enabled by defining the macro
//   BEAM_LOADER_READBACK_EN; without it the sequence ends after the second
//   write and a mismatch code is never produced.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   load_i, mask_i          start request and mask (captured on acceptance)
//   busy_o, done_o          sequence active, one-cycle end pulse
//   err_o, err_code_o       sticky error flag and code (cleared by next load)
//   wb_*_o / wb_*_i         Wishbone initiator interface
module beam_mask_wb_loader
   import pueo_beam_pkg::*;
#(
   parameter logic [14:0] BASE_ADDR = 15'h2000,
   parameter logic [7:0]  TIMEOUT   = 8'd255,
   parameter int          MAX_RETRY = 3
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              load_i,
   input  logic [NBEAMS-1:0] mask_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [14:0]       wb_adr_o,
   output logic [31:0]       wb_dat_o,
   output logic [3:0]        wb_sel_o,
   input  logic [31:0]       wb_dat_i,
   input  logic              wb_ack_i,
   input  logic              wb_err_i,
   input  logic              wb_rty_i
);

`ifdef BEAM_LOADER_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   localparam logic [14:0] ADR_REG0 = BASE_ADDR + {11'd0, MASK_REG_0};
   localparam logic [14:0] ADR_REG1 = BASE_ADDR + {11'd0, MASK_REG_1};

   loader_state_t     state;
   logic [NBEAMS-1:0] mask_q;
   logic              rd_phase;  // GAP precedes RD1 rather than WR1
   logic              issue_q;   // first cycle of RD0, launches the read
   logic              mism_q;    // RD0 comparison result
   logic              err_q;
   logic [1:0]        code_q;

   logic              accept;
   logic              acc_start;
   logic              acc_we;
   logic [14:0]       acc_adr;
   logic [31:0]       acc_dat;
   logic              acc_done;
   logic [31:0]       acc_rdata;
   logic [1:0]        acc_status;
   logic [31:0]       wr1_data;
   logic              fin;
   logic [1:0]        fin_code;

   assign accept     = (state == ST_IDLE) && load_i;
   assign wb_sel_o   = 4'hF;
   // Acceptance clears the error report in the accepting cycle itself.
   assign err_o      = err_q && !accept;
   assign err_code_o = accept ? ERR_NONE : code_q;

   always_comb begin
      wr1_data                = {2'b00, mask_q[NBEAMS-1:18]};
      wr1_data[UPDATE_BIT]    = 1'b1;
   end

   // Access launch. WR0 starts straight from the load (mask_i is used since
   // mask_q is only written on this edge); later accesses start from GAP or
   // the first RD0 cycle, which is the single idle bus cycle between them.
   always_comb begin
      acc_start = 1'b0;
      acc_we    = 1'b0;
      acc_adr   = ADR_REG0;
      acc_dat   = 32'd0;
      if (accept) begin
         acc_start = 1'b1;
         acc_we    = 1'b1;
         acc_dat   = {14'd0, mask_i[17:0]};
      end else if (state == ST_GAP) begin
         acc_start = 1'b1;
         acc_adr   = ADR_REG1;
         if (!rd_phase) begin
            acc_we  = 1'b1;
            acc_dat = wr1_data;
         end
      end else if ((state == ST_RD0) && issue_q) begin
         acc_start = 1'b1;
      end
   end

   // Decide whether the current access ends the sequence, and with what code.
   always_comb begin
      fin      = 1'b0;
      fin_code = ERR_NONE;
      if (acc_done) begin
         if (acc_status != ERR_NONE) begin
            fin      = 1'b1;
            fin_code = acc_status;
         end else begin
            case (state)
               ST_WR1: fin = !READBACK;
               ST_RD1: begin
                  fin = 1'b1;
                  if (mism_q ||
                      ((acc_rdata & 32'h3FFF_FFFF) != {2'b00, mask_q[NBEAMS-1:18]}))
                     fin_code = ERR_MISMATCH;
               end
               default: fin = 1'b0;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= ST_IDLE;
         mask_q   <= {NBEAMS{1'b1}};
         rd_phase <= 1'b0;
         issue_q  <= 1'b0;
         mism_q   <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         done_o  <= 1'b0;
         issue_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_i) begin
                  mask_q   <= mask_i;
                  err_q    <= 1'b0;
                  code_q   <= ERR_NONE;
                  busy_o   <= 1'b1;
                  rd_phase <= 1'b0;
                  mism_q   <= 1'b0;
                  state    <= ST_WR0;
               end
            end
            ST_WR0: if (acc_done) state <= ST_GAP;
            ST_GAP: state <= rd_phase ? ST_RD1 : ST_WR1;
            ST_WR1: begin
               if (acc_done) begin
                  state   <= ST_RD0;
                  issue_q <= 1'b1;
               end
            end
            ST_RD0: begin
               if (acc_done) begin
                  mism_q   <= (acc_rdata & 32'h0003_FFFF) != {14'd0, mask_q[17:0]};
                  rd_phase <= 1'b1;
                  state    <= ST_GAP;
               end
            end
            ST_RD1: state <= state;
            ST_DONE: begin
               busy_o <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         // Sequence end (success or any error) overrides the step above.
         if (fin) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
            err_q  <= (fin_code != ERR_NONE);
            code_q <= fin_code;
         end
      end
   end

   wb_single_access #(
      .TIMEOUT  (TIMEOUT),
      .MAX_RETRY(MAX_RETRY)
   ) u_access (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .start   (acc_start),
      .we      (acc_we),
      .adr     (acc_adr),
      .dat     (acc_dat),
      .done    (acc_done),
      .rdata   (acc_rdata),
      .status  (acc_status),
      .bus_cyc (wb_cyc_o),
      .bus_stb (wb_stb_o),
      .bus_we  (wb_we_o),
      .bus_adr (wb_adr_o),
      .bus_wdat(wb_dat_o),
      .bus_rdat(wb_dat_i),
      .bus_ack (wb_ack_i),
      .bus_err (wb_err_i),
      .bus_rty (wb_rty_i)
   );

endmodule

// File: tb/tb_beam_mask_wb_loader.sv
module tb_beam_mask_wb_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [47:0] mask;
   logic        busy, done, err_flag;
   logic [1:0]  code;
   logic        wb_cyc, wb_stb, wb_we;
   logic [14:0] wb_adr;
   logic [31:0] wb_wdat;
   logic [3:0]  wb_sel;
   logic [31:0] wb_rdat;
   logic        wb_ack, wb_err, wb_rty;

`ifdef BEAM_LOADER_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   // Scoreboard entries are {we, adr, dat} of every strobe issue.
   logic [47:0] exp_q[$];
   logic [47:0] log_q[$];
   int          gap_q[$];
   int          hi_q[$];

   // Responder controls
   bit          never_ack = 1'b0;
   bit          prio_all = 1'b0;
   bit          prio_ack_rty = 1'b0;
   bit          rd_flip = 1'b0;
   int          rty_left = 0;
   logic [31:0] reg0 = 32'd0;
   logic [31:0] reg1 = 32'd0;

   // Monitor state
   bit          stb_prev = 1'b0, cyc_prev = 1'b0, have_prev = 1'b0;
   int          low_cnt = 0, hi_cnt = 0, lat_cnt = 0, done_cnt = 0, unstable = 0;
   logic [14:0] cur_adr = 15'd0;
   logic [31:0] cur_dat = 32'd0;

   always #5 clk = ~clk;

   beam_mask_wb_loader #(.TIMEOUT(8'd16)) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .load_i    (load),
      .mask_i    (mask),
      .busy_o    (busy),
      .done_o    (done),
      .err_o     (err_flag),
      .err_code_o(code),
      .wb_cyc_o  (wb_cyc),
      .wb_stb_o  (wb_stb),
      .wb_we_o   (wb_we),
      .wb_adr_o  (wb_adr),
      .wb_dat_o  (wb_wdat),
      .wb_sel_o  (wb_sel),
      .wb_dat_i  (wb_rdat),
      .wb_ack_i  (wb_ack),
      .wb_err_i  (wb_err),
      .wb_rty_i  (wb_rty)
   );

   // Bus monitor and responder, on the falling edge. Responses come in the
   // second strobe cycle of each issue (ack latency 2).
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (wb_cyc && wb_stb && !stb_prev) begin
         log_q.push_back({wb_we, wb_adr, wb_wdat});
         if (have_prev) gap_q.push_back(low_cnt);
         have_prev = 1'b1;
         low_cnt   = 0;
         cur_adr   = wb_adr;
         cur_dat   = wb_wdat;
         lat_cnt   = 0;
      end
      if (!wb_cyc && have_prev) low_cnt++;
      if (wb_cyc && wb_stb && (wb_adr !== cur_adr || wb_wdat !== cur_dat)) unstable++;
      if (wb_cyc) hi_cnt++;
      else if (cyc_prev) begin
         hi_q.push_back(hi_cnt);
         hi_cnt = 0;
      end
      stb_prev = wb_stb;
      cyc_prev = wb_cyc;
      wb_ack  = 1'b0;
      wb_err  = 1'b0;
      wb_rty  = 1'b0;
      wb_rdat = 32'd0;
      if (wb_cyc && wb_stb && !never_ack) begin
         lat_cnt++;
         if (lat_cnt == 2) begin
            if (prio_all) begin
               wb_ack = 1'b1; wb_err = 1'b1; wb_rty = 1'b1;
               prio_all = 1'b0;
            end else if (wb_we && wb_adr == 15'h200C && rty_left > 0) begin
               wb_rty = 1'b1;
               rty_left--;
            end else if (prio_ack_rty) begin
               wb_ack = 1'b1; wb_rty = 1'b1;
               prio_ack_rty = 1'b0;
            end else begin
               wb_ack = 1'b1;
               if (wb_we) begin
                  if (wb_adr == 15'h2008) reg0 = wb_wdat;
                  else reg1 = wb_wdat;
               end else begin
                  wb_rdat = (wb_adr == 15'h200C) ? (reg1 ^ {31'd0, rd_flip}) : reg0;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void push_exp(input logic we, input logic [14:0] a, input logic [31:0] d);
      exp_q.push_back({we, a, d});
   endfunction

   function automatic void push_reads();
      if (RB) begin
         push_exp(1'b0, 15'h2008, 32'd0);
         push_exp(1'b0, 15'h200C, 32'd0);
      end
   endfunction

   task automatic clear_mon();
      log_q.delete();
      exp_q.delete();
      gap_q.delete();
      hi_q.delete();
      have_prev = 1'b0;
      low_cnt   = 0;
   endtask

   // Load in IDLE: checks the error report is cleared in the acceptance
   // cycle and the strobe appears one cycle after the load.
   task automatic do_load(input logic [47:0] m);
      @(posedge clk); #1;
      load = 1'b1;
      mask = m;
      @(negedge clk);
      check("err_o_clear_on_accept", 64'(err_flag), 64'd0);
      check("err_code_clear_on_accept", 64'(code), 64'd0);
      @(posedge clk); #1;
      load = 1'b0;
      mask = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      check("first_strobe", 64'({wb_cyc, wb_stb, wb_we, busy}), 64'b1111);
   endtask

   task automatic wait_done(input logic [1:0] exp_code, input logic exp_err);
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      check("busy_in_done", 64'(busy), 64'd1);
      check("err_code", 64'(code), 64'(exp_code));
      check("err_o", 64'(err_flag), 64'(exp_err));
      @(negedge clk);
      check("done_one_cycle", 64'({done, busy, wb_cyc}), 64'd0);
      check("idle_bus_data", 64'({wb_we, wb_wdat}), 64'd0);
   endtask

   task automatic check_log();
      check("log_len", 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < log_q.size()) check($sformatf("log[%0d]", i), 64'(log_q[i]), 64'(exp_q[i]));
      for (int i = 0; i < gap_q.size(); i++)
         check($sformatf("gap[%0d]", i), 64'(gap_q[i]), 64'd1);
   endtask

   initial begin
      rst  = 1'b1;
      load = 1'b0;
      mask = 48'd0;
      repeat (2) @(negedge clk);
      check("reset_status", 64'({busy, done, err_flag, code}), 64'd0);
      check("reset_bus_ctl", 64'({wb_cyc, wb_stb, wb_we, wb_sel}), 64'h0F);
      check("reset_bus_adr_dat", 64'({wb_adr, wb_wdat}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic load, ack latency 2
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0003_FFFF);
      push_exp(1'b1, 15'h200C, 32'h8000_0000);
      push_reads();
      do_load(48'h0000_0003_FFFF);
      wait_done(2'b00, 1'b0);
      check_log();
      check("ack_latency_len", 64'(hi_q.size() > 0), 64'd1);
      if (hi_q.size() > 0) check("ack_latency", 64'(hi_q[0]), 64'd2);

      // Mixed-pattern mask split across the two registers
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0002_C3C3);
      push_exp(1'b1, 15'h200C, 32'hA969_5696);
      push_reads();
      do_load(48'hA5A5_5A5A_C3C3);
      wait_done(2'b00, 1'b0);
      check_log();

      // Responder never answers: timeout after 16 strobe cycles, no WR1
      never_ack = 1'b1;
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0003_FFFF);
      do_load(48'hFFFF_FFFF_FFFF);
      wait_done(2'b10, 1'b1);
      check_log();
      check("timeout_len", 64'(hi_q.size()), 64'd1);
      if (hi_q.size() > 0) check("timeout_cycles", 64'(hi_q[0]), 64'd16);
      never_ack = 1'b0;

      // Three retries on WR1 then ack (also clears the previous error)
      rty_left = 3;
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0003_FFFF);
      repeat (4) push_exp(1'b1, 15'h200C, 32'hBFFF_FFFF);
      push_reads();
      do_load(48'hFFFF_FFFF_FFFF);
      wait_done(2'b00, 1'b0);
      check_log();

      // Four retries on WR1: retries exhausted
      rty_left = 4;
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0003_FFFF);
      repeat (4) push_exp(1'b1, 15'h200C, 32'hBFFF_FFFF);
      do_load(48'hFFFF_FFFF_FFFF);
      wait_done(2'b01, 1'b1);
      check_log();
      check("rty_consumed", 64'(rty_left), 64'd0);

      // err, rty and ack together on WR0: err wins
      prio_all = 1'b1;
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0000_0000);
      do_load(48'h0000_0000_0000);
      wait_done(2'b01, 1'b1);
      check_log();

      // rty and ack together on WR0: rty wins, WR0 re-issued then acked
      prio_ack_rty = 1'b1;
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0000_0000);
      push_exp(1'b1, 15'h2008, 32'h0000_0000);
      push_exp(1'b1, 15'h200C, 32'h8000_0001);
      push_reads();
      do_load(48'h0000_0004_0000);
      wait_done(2'b00, 1'b0);
      check_log();

      // Second load during WR1 is ignored
      begin
         bit found = 1'b0;
         clear_mon();
         push_exp(1'b1, 15'h2008, 32'h0000_0001);
         push_exp(1'b1, 15'h200C, 32'hA000_0000);
         push_reads();
         do_load(48'h8000_0000_0001);
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wb_cyc && wb_adr == 15'h200C) begin
               found = 1'b1;
               break;
            end
         end
         check("wr1_reached", 64'(found), 64'd1);
         @(posedge clk); #1;
         load = 1'b1;
         mask = 48'h5555_5555_5555;
         @(posedge clk); #1;
         load = 1'b0;
         wait_done(2'b00, 1'b0);
         repeat (3) @(negedge clk);
         check("ignored_load_idle", 64'({busy, wb_cyc}), 64'd0);
         check_log();
      end

`ifdef BEAM_LOADER_READBACK_EN
      // Readback with RD1 bit 0 flipped
      rd_flip = 1'b1;
      clear_mon();
      do_load(48'h0000_0000_0001);
      wait_done(2'b11, 1'b1);
      rd_flip = 1'b0;
      clear_mon();
      do_load(48'h0000_0000_0001);
      wait_done(2'b00, 1'b0);
`endif

      // Reset mid-WR0: bus drops at once, no done pulse
      begin
         int d0;
         never_ack = 1'b1;
         clear_mon();
         do_load(48'h0000_0000_00FF);
         repeat (3) @(negedge clk);
         d0 = done_cnt;
         #2;
         rst = 1'b1;
         #1;
         check("rst_bus_drop", 64'({wb_cyc, wb_stb, wb_we, wb_sel}), 64'h0F);
         check("rst_status", 64'({busy, done, err_flag, code}), 64'd0);
         repeat (3) @(negedge clk);
         check("rst_no_done", 64'(done_cnt), 64'(d0));
         @(posedge clk); #1;
         rst = 1'b0;
         never_ack = 1'b0;
      end

      // Recovery after reset
      clear_mon();
      push_exp(1'b1, 15'h2008, 32'h0000_00FF);
      push_exp(1'b1, 15'h200C, 32'h8000_0000);
      push_reads();
      do_load(48'h0000_0000_00FF);
      wait_done(2'b00, 1'b0);
      check_log();

      check("addr_data_stable", 64'(unstable), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/beam_mask_wb_loader.md
BEAM_MASK_WB_LOADER -- requirements
Module: beam_mask_wb_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h2000, base of the beam-mask register block.
REQ-002 SHALL have parameter TIMEOUT, default 255 (8-bit), the maximum wait for ack in cycles.
REQ-003 SHALL have parameter MAX_RETRY, default 3, the number of re-issues allowed on wb_rty_i.
REQ-004 SHALL have the following ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- load_i  in  1  start-request pulse.
- mask_i  in  48  beam mask; bit=1 enables the beam.
- busy_o  out  1  sequence in progress.
- done_o  out  1  1-cycle pulse when the sequence ends (success or error).
- err_o  out  1  sticky error flag; cleared by the next accepted load.
- err_code_o  out  2  00 none, 01 bus error/retries exhausted, 10 timeout, 11 readback mismatch.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone initiator controls.
- wb_adr_o  out  15  byte address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects, always 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  responder terminations.

Function
REQ-005 load_i is accepted only in IDLE; mask_i is captured in the same cycle; load_i in any other state SHALL be ignored.
REQ-006 State machine: IDLE -> WR0 -> GAP -> WR1 -> [RD0 -> GAP -> RD1] -> DONE -> IDLE; any error SHALL go directly to DONE.
REQ-007 WR0 write cycle:
- address BASE_ADDR+8
- data {14'b0, mask[17:0]}
- bit 31 = 0, so no update is triggered.
REQ-008 WR1 write cycle:
- address BASE_ADDR+'hC
- data {1'b1, 1'b0, mask[47:18]}
- bit 31 = 1 requests an atomic mask update.
REQ-009 Access timing: cyc, stb and we (writes only) SHALL assert the cycle after state entry and hold until ack, err, rty or timeout; all SHALL deassert the cycle after termination.
REQ-010 GAP: cyc and stb SHALL be low for exactly 1 cycle between consecutive accesses.
REQ-011 Load-to-first-strobe latency SHALL be 1 cycle; wb_adr_o and wb_dat_o SHALL be stable while stb is high.
REQ-012 Timeout: an 8-bit counter resets at each access start. If the count reaches TIMEOUT with no termination:
- drop cyc/stb
- set err_code 10
- go to DONE.
REQ-013 wb_err_i SHALL end the access with err_code 01 and go to DONE.
REQ-014 wb_rty_i SHALL end the access and re-issue it after one GAP cycle.
- After MAX_RETRY re-issues, a further rty SHALL yield err_code 01.
- The retry count resets per access.
REQ-015 If ack, err and rty coincide, priority SHALL be err > rty > ack.
REQ-016 DONE SHALL last 1 cycle with done_o=1; busy_o SHALL be 1 in every state except IDLE.
REQ-017 Accepting a load SHALL clear err_o and err_code_o in the same cycle.
REQ-018 wb_dat_o SHALL be 0 whenever wb_we_o=0.

Reset
REQ-019 Assertion of wb_rst_i SHALL asynchronously force:
- state IDLE
- all wb_*_o outputs 0, except wb_sel_o=4'hF
- busy_o, done_o, err_o = 0; err_code_o = 00
- counters 0; captured mask = 48'hFFFFFFFFFFFF.
REQ-020 Reset mid-access SHALL drop cyc/stb immediately, with no done_o pulse.

Configuration
REQ-021 Macro BEAM_LOADER_READBACK_EN controls readback.
- Defined: after WR1, RD0 reads BASE_ADDR+8 and RD1 reads BASE_ADDR+'hC.
- Comparison: RD0 bits [17:0] against mask[17:0]; RD1 bits [29:0] against mask[47:18].
- Any mismatch SHALL give err_code 11 after RD1 completes.
- Not defined: WR1 goes directly to DONE, and err_code 11 is never produced.

Structure
REQ-022 Shared package pueo_beam_pkg SHALL hold:
- the state enum
- register offsets MASK_REG_0=4'h8 and MASK_REG_1=4'hC
- bit positions UPDATE_BIT=31 and NBEAMS=48
- the err_code constants.
REQ-023 A single sub-module, wb_single_access, SHALL perform one read or write access, including the timeout and retry handling.
- Inputs: start, we, adr, dat.
- Outputs: done, rdata, status.
- The top module sequences this access engine.

Verification
REQ-024 Load mask 48'h0000_0003_FFFF with ack at latency 2. Required response:
- writes: 0x2008 <- 0x0003FFFF, then 0x200C <- 0x80000000
- exactly 1 GAP cycle between them
- done pulse; err_code 00.
REQ-025 Load mask 48'hFFFF_FFFF_FFFF with the responder never acking and TIMEOUT=16:
- cyc drops after 16 cycles of WR0
- err_code 10; done pulse; no WR1 issued.
REQ-026 wb_rty_i on WR1 three times, then ack: WR1 is issued 4 times and err_code is 00. Four rty: err_code 01 after the 4th rty.
REQ-027 Readback enabled, with the responder returning RD1 data with bit 0 flipped: err_code 11 and err_o=1.
- A new load SHALL clear err_o in its acceptance cycle.
REQ-028 Second load_i during WR1 is ignored. wb_rst_i asserted mid-WR0:
- cyc=0 immediately
- busy_o=0
- no done_o pulse.
